// File: rtl/wb_pkg.sv
// Shared types for the load/ALU writeback path: field widths, the writeback entry
// and the ROB-relative age compare used by mispredict flushes.
package wb_pkg;
  localparam int IDX_W     = 6;
  localparam int PHY_W     = 6;
  localparam int DAT_W     = 16;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] indx;
    logic [PHY_W-1:0] phy_addr;
    logic [DAT_W-1:0] data;
    logic             reg_wrt;
  } wb_entry_t;

  // Ages are distances from the ROB head with 6-bit wraparound; larger age = younger.
  function automatic logic is_younger(input logic [IDX_W-1:0] x,
                                      input logic [IDX_W-1:0] br,
                                      input logic [IDX_W-1:0] head);
    logic [IDX_W-1:0] w_age_x;
    logic [IDX_W-1:0] w_age_br;
    w_age_x  = x - head;
    w_age_br = br - head;
    return w_age_x > w_age_br;
  endfunction
endpackage

// File: rtl/ld_wb_fifo.sv
// Load-result FIFO with per-entry valid bits; a flush clears valid on younger entries
// in place. Head is visible combinationally; o_full holds off the load queue.
module ld_wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  wb_entry_t        i_push_ent,
  input  logic             i_pop,
  input  logic             i_flsh,
  input  logic [IDX_W-1:0] i_flsh_indx,
  input  logic [IDX_W-1:0] i_rob_head,
  output logic             o_full,
  output logic             o_empty,
  output wb_entry_t        o_head
);
  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  wb_entry_t        r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_head];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // Killed entries keep their slot; the arbiter drains them without a write.
      for (int i = 0; i < DEPTH; i++) begin
        if (i_flsh && is_younger(r_mem[i].indx, i_flsh_indx, i_rob_head))
          r_mem[i].vld <= 1'b0;
      end
      if (w_push) begin
        r_mem[r_tail] <= i_push_ent;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ld_wb_arbiter.sv
// Arbitrates one regfile write port between the ALU (1 edge) and buffered loads (2 edges);
// ld_stll when the FIFO is full, alu_stll when a buffered load has been starved STARV_MAX cycles.
module ld_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int STARV_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_ld,
  input  logic [IDX_W-1:0] indx_ld,
  input  logic [PHY_W-1:0] phy_addr_ld,
  input  logic [DAT_W-1:0] data_ld,
  input  logic             reg_wrt_ld,
  input  logic             alu_vld,
  input  logic [IDX_W-1:0] alu_indx,
  input  logic [PHY_W-1:0] alu_phy_addr,
  input  logic [DAT_W-1:0] alu_data,
  input  logic             alu_reg_wrt,
  input  logic             flsh,
  input  logic [IDX_W-1:0] flsh_indx,
  input  logic [IDX_W-1:0] rob_head,
  output logic             ld_stll,
  output logic             alu_stll,
  output logic             wb_vld,
  output logic [IDX_W-1:0] wb_indx,
  output logic [PHY_W-1:0] wb_phy_addr,
  output logic [DAT_W-1:0] wb_data,
  output logic             wb_reg_wrt
);
  localparam int SW = (STARV_MAX < 1) ? 1 : $clog2(STARV_MAX + 1);
  localparam logic [SW-1:0] STARV_LIM = SW'(STARV_MAX);

  logic [SW-1:0] r_starv;
  wb_entry_t     r_wb;

  wb_entry_t w_push_ent;
  wb_entry_t w_head;
  wb_entry_t w_win;
  logic      w_full;
  logic      w_empty;
  logic      w_head_vld;
  logic      w_push;
  logic      w_pop;
  logic      w_alu_in;
  logic      w_alu_win;
  logic      w_ld_win;
  logic      w_kill;

  assign w_push_ent = '{vld: 1'b1, indx: indx_ld, phy_addr: phy_addr_ld,
                        data: data_ld, reg_wrt: reg_wrt_ld};
  assign w_push     = vld_ld && !w_full && !(flsh && is_younger(indx_ld, flsh_indx, rob_head));

  ld_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_ent  (w_push_ent),
    .i_pop       (w_pop),
    .i_flsh      (flsh),
    .i_flsh_indx (flsh_indx),
    .i_rob_head  (rob_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  assign w_head_vld = !w_empty && w_head.vld;
  assign ld_stll    = w_full;
  assign alu_stll   = (r_starv == STARV_LIM) && w_head_vld;

  // A younger ALU result under flush is treated as absent so a load can take the port.
  assign w_alu_in  = alu_vld && !(flsh && is_younger(alu_indx, flsh_indx, rob_head));
  assign w_alu_win = w_alu_in && !alu_stll;
  assign w_ld_win  = !w_alu_win && w_head_vld;
  assign w_pop     = w_ld_win || (!w_empty && !w_head.vld);

  always_comb begin
    w_win = '0;
    if (w_alu_win) begin
      w_win.vld      = 1'b1;
      w_win.indx     = alu_indx;
      w_win.phy_addr = alu_phy_addr;
      w_win.data     = alu_data;
      w_win.reg_wrt  = alu_reg_wrt;
    end else if (w_ld_win) begin
      w_win = w_head;
    end
  end

  assign w_kill = flsh && is_younger(w_win.indx, flsh_indx, rob_head);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb    <= '0;
      r_starv <= '0;
    end else begin
      r_wb.vld <= w_win.vld && !w_kill;
      if (w_win.vld) begin
        r_wb.indx     <= w_win.indx;
        r_wb.phy_addr <= w_win.phy_addr;
        r_wb.data     <= w_win.data;
        r_wb.reg_wrt  <= w_win.reg_wrt;
      end
      if (w_head_vld && w_alu_win) begin
        if (r_starv != STARV_LIM) r_starv <= r_starv + 1'b1;
      end else if (w_ld_win || w_empty) begin
        r_starv <= '0;
      end
    end
  end

  assign wb_vld      = r_wb.vld;
  assign wb_indx     = r_wb.indx;
  assign wb_phy_addr = r_wb.phy_addr;
  assign wb_data     = r_wb.data;
  assign wb_reg_wrt  = r_wb.reg_wrt;
endmodule

// File: tb/tb_ld_wb_arbiter.sv
// Directed bench: stimulus pushes hand-computed writebacks into a scoreboard queue,
// a negedge monitor pops and compares each wb_vld beat.
module tb_ld_wb_arbiter;
  import wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        vld_ld;
  logic [5:0]  indx_ld;
  logic [5:0]  phy_addr_ld;
  logic [15:0] data_ld;
  logic        reg_wrt_ld;
  logic        alu_vld;
  logic [5:0]  alu_indx;
  logic [5:0]  alu_phy_addr;
  logic [15:0] alu_data;
  logic        alu_reg_wrt;
  logic        flsh;
  logic [5:0]  flsh_indx;
  logic [5:0]  rob_head;
  logic        ld_stll;
  logic        alu_stll;
  logic        wb_vld;
  logic [5:0]  wb_indx;
  logic [5:0]  wb_phy_addr;
  logic [15:0] wb_data;
  logic        wb_reg_wrt;

  int n_cmp = 0;
  int n_err = 0;
  wb_entry_t sb[$];

  ld_wb_arbiter #(.DEPTH(4), .STARV_MAX(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .vld_ld       (vld_ld),
    .indx_ld      (indx_ld),
    .phy_addr_ld  (phy_addr_ld),
    .data_ld      (data_ld),
    .reg_wrt_ld   (reg_wrt_ld),
    .alu_vld      (alu_vld),
    .alu_indx     (alu_indx),
    .alu_phy_addr (alu_phy_addr),
    .alu_data     (alu_data),
    .alu_reg_wrt  (alu_reg_wrt),
    .flsh         (flsh),
    .flsh_indx    (flsh_indx),
    .rob_head     (rob_head),
    .ld_stll      (ld_stll),
    .alu_stll     (alu_stll),
    .wb_vld       (wb_vld),
    .wb_indx      (wb_indx),
    .wb_phy_addr  (wb_phy_addr),
    .wb_data      (wb_data),
    .wb_reg_wrt   (wb_reg_wrt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wb(input logic [5:0] i, input logic [5:0] p, input logic [15:0] d,
                        input logic w);
    wb_entry_t e;
    e.vld = 1'b1; e.indx = i; e.phy_addr = p; e.data = d; e.reg_wrt = w;
    sb.push_back(e);
  endtask

  task automatic set_ld(input logic [5:0] i, input logic [5:0] p, input logic [15:0] d,
                        input logic w);
    vld_ld = 1'b1; indx_ld = i; phy_addr_ld = p; data_ld = d; reg_wrt_ld = w;
  endtask

  task automatic set_alu(input logic [5:0] i, input logic [5:0] p, input logic [15:0] d,
                         input logic w);
    alu_vld = 1'b1; alu_indx = i; alu_phy_addr = p; alu_data = d; alu_reg_wrt = w;
  endtask

  task automatic clr();
    vld_ld = 1'b0; alu_vld = 1'b0; flsh = 1'b0;
  endtask

  // Check stall outputs for the current cycle, then advance to just after the next edge.
  task automatic tick(input string tag, input logic els, input logic eas);
    check({tag, "_ld_stll"}, 32'(ld_stll), 32'(els));
    check({tag, "_alu_stll"}, 32'(alu_stll), 32'(eas));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (wb_vld === 1'b1) begin
      wb_entry_t got;
      wb_entry_t e;
      got = '{vld: 1'b1, indx: wb_indx, phy_addr: wb_phy_addr, data: wb_data,
              reg_wrt: wb_reg_wrt};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got indx=%0d phy=%0d data=0x%0h wrt=%0b, want no write",
                 wb_indx, wb_phy_addr, wb_data, wb_reg_wrt);
      end else begin
        e = sb.pop_front();
        if (got !== e)
          begin
            n_err++;
            $display("FAIL wb_entry: got indx=%0d phy=%0d data=0x%0h wrt=%0b, want indx=%0d phy=%0d data=0x%0h wrt=%0b",
                     got.indx, got.phy_addr, got.data, got.reg_wrt,
                     e.indx, e.phy_addr, e.data, e.reg_wrt);
          end
      end
    end
  end

  initial begin
    rst = 1'b1; rob_head = 6'd0; flsh_indx = 6'd0;
    indx_ld = '0; phy_addr_ld = '0; data_ld = '0; reg_wrt_ld = 1'b0;
    alu_indx = '0; alu_phy_addr = '0; alu_data = '0; alu_reg_wrt = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_wb_vld", 32'(wb_vld), 0);
    check("rst_wb_indx", 32'(wb_indx), 0);
    check("rst_wb_phy", 32'(wb_phy_addr), 0);
    check("rst_wb_data", 32'(wb_data), 0);
    check("rst_wb_wrt", 32'(wb_reg_wrt), 0);

    // Single uncontended load: two edges to writeback
    exp_wb(6'd5, 6'd2, 16'h0004, 1'b1);
    set_ld(6'd5, 6'd2, 16'h0004, 1'b1); tick("l1c0", 0, 0);
    clr(); check("l1_lat_not1", 32'(wb_vld), 0);
    tick("l1c1", 0, 0);
    check("l1_lat_2", 32'(wb_vld), 1);
    tick("l1c2", 0, 0);

    // ALU result, reg_wrt=0 passes through as completion only
    exp_wb(6'd7, 6'd3, 16'h1234, 1'b0);
    set_alu(6'd7, 6'd3, 16'h1234, 1'b0); tick("a1c0", 0, 0);
    clr(); tick("a1c1", 0, 0);

    // Five back-to-back loads against a busy ALU: fill, stall, forced load
    exp_wb(6'd10, 6'd1, 16'h1000, 1'b1);
    exp_wb(6'd11, 6'd1, 16'h1001, 1'b1);
    exp_wb(6'd12, 6'd1, 16'h1002, 1'b1);
    exp_wb(6'd13, 6'd1, 16'h1003, 1'b1);
    exp_wb(6'd20, 6'd4, 16'h2000, 1'b1);
    exp_wb(6'd14, 6'd1, 16'h1004, 1'b1);
    exp_wb(6'd21, 6'd5, 16'h2001, 1'b1);
    exp_wb(6'd22, 6'd6, 16'h2002, 1'b0);
    exp_wb(6'd23, 6'd7, 16'h2003, 1'b1);
    exp_wb(6'd24, 6'd8, 16'h2004, 1'b1);
    set_ld(6'd20, 6'd4, 16'h2000, 1'b1); set_alu(6'd10, 6'd1, 16'h1000, 1'b1); tick("f0", 0, 0);
    set_ld(6'd21, 6'd5, 16'h2001, 1'b1); set_alu(6'd11, 6'd1, 16'h1001, 1'b1); tick("f1", 0, 0);
    set_ld(6'd22, 6'd6, 16'h2002, 1'b0); set_alu(6'd12, 6'd1, 16'h1002, 1'b1); tick("f2", 0, 0);
    set_ld(6'd23, 6'd7, 16'h2003, 1'b1); set_alu(6'd13, 6'd1, 16'h1003, 1'b1); tick("f3", 0, 0);
    set_ld(6'd24, 6'd8, 16'h2004, 1'b1); set_alu(6'd14, 6'd1, 16'h1004, 1'b1); tick("f4", 1, 1);
    tick("f5", 0, 0);
    clr(); tick("f6", 1, 0);
    tick("f7", 0, 0);
    tick("f8", 0, 0);
    tick("f9", 0, 0);
    tick("f10", 0, 0);

    // Starvation: one buffered load behind three ALU wins
    exp_wb(6'd40, 6'd9, 16'h4000, 1'b1);
    exp_wb(6'd41, 6'd9, 16'h4001, 1'b1);
    exp_wb(6'd42, 6'd9, 16'h4002, 1'b1);
    exp_wb(6'd43, 6'd9, 16'h4003, 1'b1);
    exp_wb(6'd30, 6'd10, 16'h3000, 1'b1);
    exp_wb(6'd44, 6'd9, 16'h4004, 1'b1);
    set_ld(6'd30, 6'd10, 16'h3000, 1'b1); set_alu(6'd40, 6'd9, 16'h4000, 1'b1); tick("s0", 0, 0);
    vld_ld = 1'b0; set_alu(6'd41, 6'd9, 16'h4001, 1'b1); tick("s1", 0, 0);
    set_alu(6'd42, 6'd9, 16'h4002, 1'b1); tick("s2", 0, 0);
    set_alu(6'd43, 6'd9, 16'h4003, 1'b1); tick("s3", 0, 0);
    set_alu(6'd44, 6'd9, 16'h4004, 1'b1); tick("s4", 0, 1);
    tick("s5", 0, 0);
    clr(); tick("s6", 0, 0);

    // Flush with wrapped ages: rob_head=60, branch 0; 62 survives, 1/3/2 are younger
    rob_head = 6'd60;
    exp_wb(6'd61, 6'd11, 16'hA000, 1'b1);
    exp_wb(6'd61, 6'd11, 16'hA001, 1'b1);
    exp_wb(6'd61, 6'd11, 16'hA002, 1'b1);
    exp_wb(6'd62, 6'd12, 16'h0062, 1'b1);
    set_ld(6'd62, 6'd12, 16'h0062, 1'b1); set_alu(6'd61, 6'd11, 16'hA000, 1'b1); tick("x0", 0, 0);
    set_ld(6'd1, 6'd13, 16'h0001, 1'b1); set_alu(6'd61, 6'd11, 16'hA001, 1'b1); tick("x1", 0, 0);
    set_ld(6'd3, 6'd14, 16'h0003, 1'b1); set_alu(6'd61, 6'd11, 16'hA002, 1'b1); tick("x2", 0, 0);
    clr(); set_ld(6'd2, 6'd15, 16'h0002, 1'b1); flsh = 1'b1; flsh_indx = 6'd0; tick("x3", 0, 0);
    clr(); check("x3_wb_62", 32'(wb_indx), 62);
    tick("x4", 0, 0);
    check("x4_killed_pop", 32'(wb_vld), 0);
    tick("x5", 0, 0);
    check("x5_killed_pop", 32'(wb_vld), 0);
    set_alu(6'd2, 6'd16, 16'hB002, 1'b1); flsh = 1'b1; tick("x6", 0, 0);
    check("x6_alu_dropped", 32'(wb_vld), 0);
    exp_wb(6'd63, 6'd17, 16'hB063, 1'b1);
    set_alu(6'd63, 6'd17, 16'hB063, 1'b1); flsh = 1'b1; tick("x7", 0, 0);
    clr(); check("x7_alu_older", 32'(wb_vld), 1);
    tick("x8", 0, 0);
    tick("x9", 0, 0);

    // Reset with three loads buffered: none may ever be written
    rob_head = 6'd0;
    exp_wb(6'd50, 6'd18, 16'h7000, 1'b1);
    exp_wb(6'd51, 6'd18, 16'h7001, 1'b1);
    exp_wb(6'd52, 6'd18, 16'h7002, 1'b1);
    set_ld(6'd56, 6'd20, 16'h5000, 1'b1); set_alu(6'd50, 6'd18, 16'h7000, 1'b1); tick("r0", 0, 0);
    set_ld(6'd57, 6'd20, 16'h5001, 1'b1); set_alu(6'd51, 6'd18, 16'h7001, 1'b1); tick("r1", 0, 0);
    set_ld(6'd58, 6'd20, 16'h5002, 1'b1); set_alu(6'd52, 6'd18, 16'h7002, 1'b1); tick("r2", 0, 0);
    clr(); rst = 1'b1; set_ld(6'd53, 6'd20, 16'h5003, 1'b1); tick("r3", 0, 0);
    rst = 1'b0; clr();
    check("r_wb_vld", 32'(wb_vld), 0);
    check("r_wb_indx", 32'(wb_indx), 0);
    check("r_wb_data", 32'(wb_data), 0);
    exp_wb(6'd55, 6'd21, 16'h5555, 1'b1);
    set_ld(6'd55, 6'd21, 16'h5555, 1'b1); tick("r4", 0, 0);
    clr();
    for (int k = 0; k < 6; k++) tick("r_idle", 0, 0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
